// File: rtl/fwd_axis_reader_pkg.sv
// Shared definitions for the forwarder-side AXI-Stream packet reader:
// FSM encoding, byte-count helper and last-beat keep mask.
`ifndef FWD_CLOG2
`define FWD_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package fwd_axis_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_READ,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  localparam int unsigned MAX_BYTES = 128;

  function automatic int unsigned bytes_of(input int unsigned dw);
    return dw / 8;
  endfunction

  // Byte 0 sits in the MSB lane, so a partial beat keeps the top 'rem' lanes.
  function automatic logic [MAX_BYTES-1:0] last_keep(input logic [7:0] rem,
                                                     input int unsigned nbytes);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if ((i < nbytes) && ((rem == 8'd0) || (i >= nbytes - {24'd0, rem})))
        m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fwd_axis_reader_out_fifo.sv
// First-word-fall-through synchronous FIFO buffering packet words ahead of
// the AXI-Stream output; accepts a push while full if a pop happens too.
module fwd_out_fifo
  import fwd_axis_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PW = `FWD_CLOG2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? bump(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/fwd_axis_reader.sv
// Claims a finished packet from the forwarder arbiter, reads it out of packet
// memory under a credit limit and streams it as AXI-Stream with the reorder tag.
module fwd_axis_reader
  import fwd_axis_reader_pkg::*;
#(
  parameter int unsigned PACKMEM_ADDR_WIDTH = 8,
  parameter int unsigned PACKMEM_DATA_WIDTH = 64,
  parameter int unsigned PLEN_WIDTH         = 32,
  parameter int unsigned TAG_WIDTH          = 6,
  parameter int unsigned SEL_LAT            = 1,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [PACKMEM_ADDR_WIDTH-1:0]     addr,
  output logic                              rd_en,
  input  logic [PACKMEM_DATA_WIDTH-1:0]     rd_data,
  input  logic [TAG_WIDTH-1:0]              rd_reorder_tag,
  input  logic                              rd_data_vld,
  input  logic [PLEN_WIDTH-1:0]             byte_len,
  output logic                              done,
  input  logic                              rdy,
  output logic                              ack,
  output logic [PACKMEM_DATA_WIDTH-1:0]     m_tdata,
  output logic [PACKMEM_DATA_WIDTH/8-1:0]   m_tkeep,
  output logic                              m_tlast,
  output logic [TAG_WIDTH-1:0]              m_tuser,
  output logic                              m_tvalid,
  input  logic                              m_tready
);
  localparam int unsigned AW    = PACKMEM_ADDR_WIDTH;
  localparam int unsigned DW    = PACKMEM_DATA_WIDTH;
  localparam int unsigned BYTES = bytes_of(DW);
  localparam int unsigned LW    = PLEN_WIDTH + 1;
  localparam int unsigned NWW   = AW + 1;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CSW   = CW + 1;
  localparam int unsigned SW    = `FWD_CLOG2(SEL_LAT + 1);
  localparam int unsigned FW    = DW + BYTES + 1 + TAG_WIDTH;
  localparam logic [LW-1:0] MAX_WORDS = LW'(1) << AW;

  state_t                state_q, state_d;
  logic [SW-1:0]         cnt_q, cnt_d;
  logic [NWW-1:0]        nwords_q, nwords_d;
  logic [NWW-1:0]        rd_idx_q, rd_idx_d;
  logic [NWW-1:0]        ret_idx_q, ret_idx_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [BYTES-1:0]      keep_last_q, keep_last_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;

  logic [PLEN_WIDTH-1:0] len_rem;
  logic [LW-1:0]         len_words;
  logic                  credit, push, pop, push_last;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [FW-1:0]         push_word, pop_word;

  // Words are pushed only for reads we actually issued; stray returns are dropped.
  assign push      = rd_data_vld && (outst_q != '0);
  assign pop       = m_tvalid && m_tready;
  assign push_last = (ret_idx_q == nwords_q - 1'b1);
  assign push_word = {rd_data, push_last ? keep_last_q : {BYTES{1'b1}}, push_last, tag_q};
  assign credit    = ({1'b0, fifo_count} + {1'b0, outst_q}) < CSW'(FIFO_DEPTH);
  assign len_rem   = byte_len % PLEN_WIDTH'(BYTES);
  assign len_words = LW'(byte_len / PLEN_WIDTH'(BYTES)) + LW'(len_rem != '0);
  assign addr      = rd_idx_q[AW-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nwords_d    = nwords_q;
    keep_last_d = keep_last_q;
    tag_d       = tag_q;
    rd_idx_d    = rd_idx_q;
    ret_idx_d   = push ? ret_idx_q + 1'b1 : ret_idx_q;
    ack         = 1'b0;
    rd_en       = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ack = 1'b1;
        if (rdy) begin
          state_d   = ST_SETTLE;
          cnt_d     = SW'(SEL_LAT);
          rd_idx_d  = '0;
          ret_idx_d = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q <= SW'(1)) begin
          tag_d = rd_reorder_tag;
          // Oversized packets are cut to the address space, sent as full beats.
          if (len_words > MAX_WORDS) begin
            nwords_d    = NWW'(MAX_WORDS);
            keep_last_d = '1;
          end else begin
            nwords_d    = NWW'(len_words);
            keep_last_d = BYTES'(last_keep(8'(len_rem), BYTES));
          end
          state_d = (byte_len == '0) ? ST_FINISH : ST_READ;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_READ: begin
        if (credit) begin
          rd_en    = 1'b1;
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_d == nwords_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((outst_q == '0) && pop && m_tlast) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    outst_d = outst_q + CW'(rd_en) - CW'(push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_idx_q  <= '0;
      ret_idx_q <= '0;
      outst_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_idx_q  <= rd_idx_d;
      ret_idx_q <= ret_idx_d;
      outst_q   <= outst_d;
    end
  end

  always_ff @(posedge clk) begin
    nwords_q    <= nwords_d;
    keep_last_q <= keep_last_d;
    tag_q       <= tag_d;
  end

  fwd_out_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (pop_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_tvalid = !fifo_empty;
  assign {m_tdata, m_tkeep, m_tlast, m_tuser} = pop_word;

  a_no_stray_vld: assert property (@(posedge clk) disable iff (rst)
    !(rd_data_vld && (outst_q == '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

endmodule
